red_led_fader: RTL and testbench

Downstream stage of the red-LED parallel output register. It takes the 18-bit on/off pattern that software writes, and drives the physical LEDR pins with per-LED 4-bit PWM brightness. Each LED ramps smoothly between off and full brightness at a programmable rate instead of switching abruptly. It sits between the LED output register's `out_port` and the top-level LEDR pins, in the same clock domain.

---
 rtl/led_pkg.sv | 16 +
 rtl/led_tick_gen.sv | 28 ++
 rtl/red_led_fader.sv | 89 ++++++++
 tb/tb_red_led_fader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and types for the LED output path (fader, blink helpers).
package led_pkg;

  localparam int LED_LEVEL_W  = 4;
  localparam int LED_PRESCALE = 50000;

  // Full-scale brightness for a given level width.
  function automatic int max_level(input int w);
    return (2 ** w) - 1;
  endfunction

  localparam int LED_MAX_LEVEL = max_level(LED_LEVEL_W);

  typedef logic [LED_LEVEL_W-1:0] level_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: tick is high for the one cycle where the count is PRESCALE-1.
module led_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_r;

  // Prescale counter, wraps after PRESCALE-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/red_led_fader.sv
// Per-LED PWM brightness fader between the red-LED output register and the LEDR pins.
module red_led_fader
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 18,
  parameter int LEVEL_W  = LED_LEVEL_W,
  parameter int PRESCALE = LED_PRESCALE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                enable,
  input  logic                fade_bypass,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                settled
);

  localparam int MAX_LEVEL = max_level(LEVEL_W);
  localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);

  logic                tick_s;
  logic [LEVEL_W-1:0]  pwm_cnt_r;
  logic [NUM_LEDS-1:0] match_s;
  logic [NUM_LEDS-1:0] on_s;

  led_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // PWM phase counter: period of MAX_LEVEL cycles so level MAX_LEVEL is always on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= {LEVEL_W{1'b0}};
    end else if (pwm_cnt_r == (MAX_LVL - LEVEL_W'(1))) begin
      pwm_cnt_r <= {LEVEL_W{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + LEVEL_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] level_nxt_s;
    logic [LEVEL_W-1:0] target_s;

    // Step one level toward the target per tick; bypass snaps immediately.
    always_comb begin
      target_s    = pattern_in[i] ? MAX_LVL : {LEVEL_W{1'b0}};
      level_nxt_s = level_r;
      if (fade_bypass) begin
        level_nxt_s = target_s;
      end else if (tick_s && (level_r < target_s)) begin
        level_nxt_s = level_r + LEVEL_W'(1);
      end else if (tick_s && (level_r > target_s)) begin
        level_nxt_s = level_r - LEVEL_W'(1);
      end else begin
        level_nxt_s = level_r;
      end
    end

    // Brightness level register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        level_r <= {LEVEL_W{1'b0}};
      end else begin
        level_r <= level_nxt_s;
      end
    end

    assign match_s[i] = (level_r == target_s);
    assign on_s[i]    = (level_r > pwm_cnt_r);
  end

  // Output registers; enable only gates the pins, not the fade state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= {NUM_LEDS{1'b0}};
      settled <= 1'b1;
    end else begin
      led_out <= enable ? on_s : {NUM_LEDS{1'b0}};
      settled <= &match_s;
    end
  end

endmodule

// File: tb/tb_red_led_fader.sv
// Scoreboard bench for red_led_fader with PRESCALE=4, LEVEL_W=4.
module tb_red_led_fader;

  localparam int N  = 18;
  localparam int P  = 4;
  localparam int ML = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] pattern_in = '0;
  logic         enable = 1'b1;
  logic         fade_bypass = 1'b0;
  logic [N-1:0] led_out;
  logic         settled;

  typedef struct packed {
    logic [N-1:0] led;
    logic         settled;
  } exp_t;

  exp_t sb_q[$];
  int   m_tcnt;
  int   m_pwm;
  int   m_lvl[N];
  int   checks = 0;
  int   passes = 0;

  red_led_fader #(.NUM_LEDS(N), .LEVEL_W(4), .PRESCALE(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .pattern_in  (pattern_in),
    .enable      (enable),
    .fade_bypass (fade_bypass),
    .led_out     (led_out),
    .settled     (settled)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_tcnt = 0;
    m_pwm  = 0;
    for (int i = 0; i < N; i++) m_lvl[i] = 0;
    sb_q.delete();
  endtask

  // One clock: predict outputs, advance the model, then compare after the edge.
  task automatic step(input string tag);
    exp_t e;
    bit   tk;
    int   tgt;
    e.settled = 1'b1;
    for (int i = 0; i < N; i++) begin
      tgt = pattern_in[i] ? ML : 0;
      e.led[i] = enable && (m_lvl[i] > m_pwm);
      if (m_lvl[i] != tgt) e.settled = 1'b0;
    end
    sb_q.push_back(e);
    tk = (m_tcnt == P - 1);
    for (int i = 0; i < N; i++) begin
      tgt = pattern_in[i] ? ML : 0;
      if (fade_bypass) m_lvl[i] = tgt;
      else if (tk && m_lvl[i] < tgt) m_lvl[i] = m_lvl[i] + 1;
      else if (tk && m_lvl[i] > tgt) m_lvl[i] = m_lvl[i] - 1;
    end
    m_tcnt = (m_tcnt == P - 1) ? 0 : m_tcnt + 1;
    m_pwm  = (m_pwm == ML - 1) ? 0 : m_pwm + 1;
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      if (led_out !== e.led || settled !== e.settled)
        $display("FAIL %s: led_out=%h settled=%b, expected led_out=%h settled=%b",
                 tag, led_out, settled, e.led, e.settled);
      else
        passes++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pattern_in = 18'h3FFFF;
    enable = 1'b1;
    fade_bypass = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (led_out !== 18'h0) $display("FAIL reset_led: got %h want 0", led_out);
    else passes++;
    checks++;
    if (settled !== 1'b1) $display("FAIL reset_settled: got %b want 1", settled);
    else passes++;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 40; k++) step("reset_release");
  endtask

  task automatic test_ramp();
    int first;
    int cnt;
    pattern_in = 18'h0;
    fade_bypass = 1'b0;
    do_reset();
    pattern_in = 18'h00001;
    first = -1;
    for (int k = 1; k <= 100; k++) begin
      step("ramp");
      if (first < 0 && settled === 1'b1) first = k;
    end
    checks++;
    if (first != 61) $display("FAIL ramp_settle_edge: got %0d want 61", first);
    else passes++;
    cnt = 0;
    for (int k = 0; k < ML; k++) begin
      step("ramp_full");
      if (led_out[0] === 1'b1) cnt++;
    end
    checks++;
    if (cnt != ML) $display("FAIL ramp_full_duty: got %0d want %0d", cnt, ML);
    else passes++;
  endtask

  task automatic test_bypass();
    pattern_in = 18'h0;
    do_reset();
    repeat (3) step("bypass_idle");
    fade_bypass = 1'b1;
    pattern_in = 18'h3FFFF;
    step("bypass_snap");
    step("bypass_on");
    checks++;
    if (led_out !== 18'h3FFFF || settled !== 1'b1)
      $display("FAIL bypass_2cyc: led_out=%h settled=%b want 3ffff 1", led_out, settled);
    else passes++;
    for (int k = 0; k < ML; k++) begin
      step("bypass_hold");
      checks++;
      if (led_out !== 18'h3FFFF) $display("FAIL bypass_hold: got %h want 3ffff", led_out);
      else passes++;
    end
  endtask

  task automatic test_enable();
    fade_bypass = 1'b1;
    pattern_in = 18'h3FFFF;
    enable = 1'b1;
    repeat (3) step("enable_pre");
    enable = 1'b0;
    step("enable_off");
    checks++;
    if (led_out !== 18'h0) $display("FAIL enable_off: got %h want 0", led_out);
    else passes++;
    repeat (5) step("enable_low");
    enable = 1'b1;
    step("enable_on");
    checks++;
    if (led_out !== 18'h3FFFF) $display("FAIL enable_on: got %h want 3ffff", led_out);
    else passes++;
    fade_bypass = 1'b0;
  endtask

  task automatic test_reversal();
    int guard;
    int ones;
    pattern_in = 18'h0;
    fade_bypass = 1'b0;
    do_reset();
    pattern_in = 18'h00001;
    guard = 0;
    while (m_lvl[0] != 7 && guard < 200) begin
      step("rev_up");
      guard++;
    end
    checks++;
    if (guard >= 200) $display("FAIL rev_reach7: timeout after %0d cycles", guard);
    else passes++;
    pattern_in = 18'h0;
    for (int k = 0; k < 40; k++) step("rev_down");
    ones = 0;
    for (int k = 0; k < 45; k++) begin
      step("rev_floor");
      if (led_out[0] === 1'b1) ones++;
    end
    checks++;
    if (ones != 0 || settled !== 1'b1)
      $display("FAIL rev_no_underflow: on_cycles=%0d settled=%b want 0 1", ones, settled);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int guard;
    pattern_in = 18'h0;
    fade_bypass = 1'b0;
    enable = 1'b1;
    do_reset();
    pattern_in = 18'h00001;
    guard = 0;
    while (m_lvl[0] != 9 && guard < 200) begin
      step("mid_up");
      guard++;
    end
    // Let the registered outputs show a lit LED before the async reset.
    while (led_out[0] !== 1'b1 && guard < 200) begin
      step("mid_wait_on");
      guard++;
    end
    checks++;
    if (guard >= 200 || settled !== 1'b0)
      $display("FAIL mid_pre: guard=%0d settled=%b want <200 0", guard, settled);
    else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (led_out !== 18'h0 || settled !== 1'b1)
      $display("FAIL mid_async: led_out=%h settled=%b want 0 1", led_out, settled);
    else passes++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 30; k++) step("mid_restart");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_bypass();
    test_enable();
    test_reversal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
